// File: rtl/step_tracker.sv
// Absolute/relative step-pulse tracker with end-of-segment endpoint check.
// Optional watchdog on a stalled segment: define STEP_TRACK_TIMEOUT_EN.
module step_tracker #(
  parameter int POS_W       = 24,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    pulse_clk,
  input  logic                    sys_rst_l,
  input  logic                    change_readyH,
  input  logic signed [15:0]      Xe,
  input  logic signed [15:0]      Ye,
  input  logic                    X_acc,
  input  logic                    X_dec,
  input  logic                    Y_acc,
  input  logic                    Y_dec,
  input  logic                    draw_overH,
  input  logic                    zero_pos,
  input  logic                    clr_err,
  output logic signed [POS_W-1:0] pos_x,
  output logic signed [POS_W-1:0] pos_y,
  output logic signed [16:0]      rel_x,
  output logic signed [16:0]      rel_y,
  output logic                    busy,
  output logic                    seg_doneH,
  output logic                    seg_okH,
  output logic                    err_conflict,
  output logic                    err_mismatch,
  output logic                    err_overflow,
  output logic                    err_timeout
);

  typedef enum logic [1:0] {IDLE, TRACK, CHECK} state_t;

  localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};

  state_t              state, state_nxt;
  logic signed [16:0]  xe_lat, ye_lat;
  logic [17:0]         exp_cnt, cnt;
  logic                seg_conf;
  logic [2:0]          n_pulse;
  logic                any_pulse, conflict, legal;
  logic signed [1:0]   dx, dy;
  logic                ovf_x, ovf_y;
  logic                seg_ok;
  logic                timeout_hit;

  function automatic logic [17:0] abs18(input logic signed [15:0] v);
    logic [17:0] s;
    s = {{2{v[15]}}, v};
    return v[15] ? 18'(-s) : s;
  endfunction

  always_comb begin
    n_pulse   = 3'(X_acc) + 3'(X_dec) + 3'(Y_acc) + 3'(Y_dec);
    any_pulse = (n_pulse != 3'd0);
    conflict  = (n_pulse > 3'd1);
    // zero_pos drops a coincident pulse entirely, including from the segment tally
    legal     = (n_pulse == 3'd1) && !zero_pos;
    dx        = !legal ? 2'sd0 : X_acc ? 2'sd1 : X_dec ? -2'sd1 : 2'sd0;
    dy        = !legal ? 2'sd0 : Y_acc ? 2'sd1 : Y_dec ? -2'sd1 : 2'sd0;
    ovf_x     = legal && ((X_acc && pos_x == POS_MAX) || (X_dec && pos_x == POS_MIN));
    ovf_y     = legal && ((Y_acc && pos_y == POS_MAX) || (Y_dec && pos_y == POS_MIN));
    seg_ok    = (rel_x == xe_lat) && (rel_y == ye_lat) && (cnt == exp_cnt) && !seg_conf;
    busy      = (state != IDLE);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (change_readyH) state_nxt = TRACK;
      TRACK:   if (draw_overH) state_nxt = CHECK;
               else if (timeout_hit) state_nxt = IDLE;
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pulse_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) state <= IDLE;
    else            state <= state_nxt;
  end

  always_ff @(posedge pulse_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      pos_x <= '0;
      pos_y <= '0;
    end else if (zero_pos) begin
      pos_x <= '0;
      pos_y <= '0;
    end else if (legal) begin
      pos_x <= pos_x + {{(POS_W-2){dx[1]}}, dx};
      pos_y <= pos_y + {{(POS_W-2){dy[1]}}, dy};
    end
  end

  always_ff @(posedge pulse_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      xe_lat    <= '0;
      ye_lat    <= '0;
      exp_cnt   <= '0;
      cnt       <= '0;
      rel_x     <= '0;
      rel_y     <= '0;
      seg_conf  <= 1'b0;
      seg_okH   <= 1'b0;
      seg_doneH <= 1'b0;
    end else begin
      seg_doneH <= 1'b0;
      case (state)
        IDLE: if (change_readyH) begin
          xe_lat   <= {Xe[15], Xe};
          ye_lat   <= {Ye[15], Ye};
          exp_cnt  <= abs18(Xe) + abs18(Ye);
          cnt      <= '0;
          rel_x    <= '0;
          rel_y    <= '0;
          seg_conf <= 1'b0;
          seg_okH  <= 1'b0;
        end
        TRACK: begin
          if (legal) begin
            rel_x <= rel_x + {{15{dx[1]}}, dx};
            rel_y <= rel_y + {{15{dy[1]}}, dy};
            if (cnt != '1) cnt <= cnt + 18'd1;
          end
          if (conflict) seg_conf <= 1'b1;
          if (!draw_overH && timeout_hit) begin
            seg_okH   <= 1'b0;
            seg_doneH <= 1'b1;
          end
        end
        CHECK: begin
          seg_okH   <= seg_ok;
          seg_doneH <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // New errors take priority over a coincident clear
  always_ff @(posedge pulse_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      err_conflict <= 1'b0;
      err_mismatch <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      err_conflict <= (err_conflict & ~clr_err) | conflict;
      err_mismatch <= (err_mismatch & ~clr_err) | ((state == CHECK) && !seg_ok);
      err_overflow <= (err_overflow & ~clr_err) | ovf_x | ovf_y;
    end
  end

`ifdef STEP_TRACK_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;

  assign timeout_hit = (state == TRACK) && !draw_overH && !any_pulse &&
                       (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge pulse_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state != TRACK || any_pulse) wd_cnt <= '0;
      else                             wd_cnt <= wd_cnt + WD_W'(1);
      err_timeout <= (err_timeout & ~clr_err) | timeout_hit;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg  = any_pulse ^ (TIMEOUT_CYC > 0);
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule
